odd_even_sort: RTL and testbench
================================

Name: odd_even_sort

Overview:
- Parametrised successor to the single-comparator bubble sorter.
- Loads a frame of DEPTH words over a valid/ready stream and sorts it in place with odd-even transposition: DEPTH/2 compare-exchanges per cycle.
- Sort direction (ascending or descending) and signed or unsigned compare are selectable per frame.
- Sorting stops early once the frame is ordered. The sorted words are streamed out with their original input positions, for the ranking stage downstream.

Parameters:
- DATA_W, 32, width of each data word.
- DEPTH, 16, words per frame. Must be even, >= 4.
- IDX_W, 8, width of the position tag. Must satisfy 2**IDX_W >= DEPTH.
- CNT_W, 8, width of the phase counter. Must satisfy 2**CNT_W > DEPTH.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous active-high reset.
- cfg_descend, in, 1: 1 = largest first. Sampled on the first accepted word of a frame.
- cfg_signed, in, 1: 1 = two's-complement compare. Sampled with cfg_descend.
- in_valid, in, 1: input word valid.
- in_ready, out, 1: block accepts an input word.
- in_data, in, DATA_W: input word.
- out_valid, out, 1: output word valid.
- out_ready, in, 1: downstream accepts the output word.
- out_data, out, DATA_W: sorted word.
- out_index, out, IDX_W: original 0-based input position of out_data.
- out_last, out, 1: marks the final word of the frame.
- busy, out, 1: high in SORT or DRAIN.
- sort_done, out, 1: one-cycle pulse on the SORT->DRAIN transition.
- phases, out, CNT_W: number of SORT phases used by the last frame. Held until the next SORT entry.

Behaviour:
- Reset (async, rst=1):
  - state=LOAD.
  - wr_ptr=0, rd_ptr=0, phase=0, clean_run=0.
  - in_ready=1.
  - out_valid=0, out_data=0, out_index=0, out_last=0.
  - busy=0, sort_done=0, phases=0.
  - Storage contents are don't-care.
  - A reset mid-frame discards the frame.
- State machine: LOAD -> SORT -> DRAIN -> LOAD. No idle state.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: data[wr_ptr]<=in_data, tag[wr_ptr]<=wr_ptr, wr_ptr++.
  - Config latched when wr_ptr==0.
  - On acceptance of word DEPTH-1: wr_ptr<=0, go to SORT next cycle. in_ready drops the following cycle.
- SORT:
  - One phase per cycle. in_ready=0, busy=1.
  - Even phase (phase[0]==0): pairs (0,1),(2,3),...,(DEPTH-2,DEPTH-1).
  - Odd phase: pairs (1,2),...,(DEPTH-3,DEPTH-2). Elements 0 and DEPTH-1 hold.
  - Exchange data and tag of a pair iff out of order:
    - Ascending: a>b.
    - Descending: a<b.
    - Equal keys never swap, so the sort is stable: equal keys leave in input order.
  - Signed compare when the latched cfg_signed=1.
  - clean_run counts consecutive phases with zero swaps; it resets to 0 on any swap.
  - Exit to DRAIN after the phase in which clean_run reaches 2, or after phase DEPTH-1 (hard bound), whichever comes first.
  - On exit: phases<=phase+1, sort_done=1 for one cycle, rd_ptr<=0.
  - Minimum SORT time 2 cycles (presorted frame). Maximum DEPTH cycles.
- DRAIN:
  - out_valid=1.
  - out_data/out_index driven from a registered copy of slot rd_ptr.
  - out_last=(rd_ptr==DEPTH-1).
  - Advance rd_ptr on out_valid&&out_ready.
  - Outputs hold stable while out_ready=0.
  - After the out_last handshake: out_valid=0 next cycle, state=LOAD, in_ready=1.
  - No overlap between DRAIN and LOAD: a frame is never accepted during DRAIN.
- Latency: first out_valid 1 cycle after sort_done.
- Width rules:
  - Tags are zero-extended wr_ptr.
  - Pointers and phase wrap only via explicit resets, never by overflow.
- in_valid while in_ready=0 is ignored. Upstream holds the data.

Decomposition:
- Package odd_even_sort_pkg holds:
  - the state enum (LOAD, SORT, DRAIN);
  - a function min_idx_w(depth) for parameter checks;
  - a packed struct {data, tag} for a slot.
- One natural sub-module, cmp_swap_cell:
  - Combinational; one pair.
  - Inputs: two slots, descend, signed.
  - Outputs: two slots, swapped flag.
  - Instantiated DEPTH/2 times for the even network and DEPTH/2-1 times for the odd network.
  - The top-level ORs the swapped flags.

Test Plan (DEPTH=8, DATA_W=16):
- Load 8,3,5,1,7,2,6,4; ascending; out_ready=1.
  - Expect out_data 1,2,3,4,5,6,7,8.
  - Expect out_index 3,5,1,7,2,6,4,0.
  - out_last on the 8th word. sort_done once. phases<=8.
- Load presorted 1..8; ascending.
  - Expect phases=2, sort_done 2 cycles after the last accept, output unchanged, indices 0..7.
- Load 5,5,2,5,9,2,0,0; descending.
  - Expect data 9,5,5,5,2,2,0,0.
  - Expect indices 4,0,1,3,2,5,6,7 (stability check).
- Load 16'hFFFF,1,16'h8000,0,...:
  - with cfg_signed=1, ascending: 16'h8000 first, 16'hFFFF before 0;
  - with cfg_signed=0: 16'h8000 and 16'hFFFF last.
- Random out_ready backpressure across DRAIN; in_valid held high throughout.
  - Expect out_data stable while stalled. Expect no input accepted until after the out_last handshake.
  - Then a second frame with the opposite cfg_descend sorts correctly.
- Assert rst for 1 cycle during SORT and during DRAIN at rd_ptr=3.
  - Expect immediate out_valid=0, busy=0, in_ready=1.
  - Next full frame sorts correctly.

Source files
------------

// File: rtl/odd_even_sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : odd_even_sort_pkg
// Description : Shared state encoding, default slot layout and parameter
//               helpers for the odd-even transposition sorter.
// Revision    : 1.0 - initial release
// ============================================================================
package odd_even_sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_IDX_W  = 8;

    // Default slot layout; the top re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_IDX_W-1:0]  tag;
    } slot_t;

    // Smallest width w with 2**w >= depth.
    function automatic int min_idx_w(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/odd_even_sort_cmp_swap_cell.sv
`default_nettype none
// ============================================================================
// Module      : cmp_swap_cell
// Description : Combinational compare-exchange of one adjacent slot pair.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_swap_cell
    import odd_even_sort_pkg::*;
#(
    parameter type SLOT_T = slot_t
) (
    input  SLOT_T i_lo,
    input  SLOT_T i_hi,
    input  logic  i_descend,
    input  logic  i_signed,
    output SLOT_T o_lo,
    output SLOT_T o_hi,
    output logic  o_swapped
);

    logic w_lo_gt;
    logic w_lo_lt;

    // Strict comparisons only, so equal keys keep their input order.
    always_comb begin
        if (i_signed) begin
            w_lo_gt = $signed(i_lo.data) > $signed(i_hi.data);
            w_lo_lt = $signed(i_lo.data) < $signed(i_hi.data);
        end else begin
            w_lo_gt = i_lo.data > i_hi.data;
            w_lo_lt = i_lo.data < i_hi.data;
        end
        o_swapped = i_descend ? w_lo_lt : w_lo_gt;
        o_lo      = o_swapped ? i_hi : i_lo;
        o_hi      = o_swapped ? i_lo : i_hi;
    end

endmodule
`default_nettype wire

// File: rtl/odd_even_sort.sv
`default_nettype none
// ============================================================================
// Module      : odd_even_sort
// Description : Frame sorter: load DEPTH words, odd-even transposition sort
//               with early exit, stream out words with original positions.
// Revision    : 1.0 - initial release
// ============================================================================
module odd_even_sort
    import odd_even_sort_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_descend,
    input  logic              cfg_signed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              sort_done,
    output logic [CNT_W-1:0]  phases
);

    localparam int               c_pairs      = DEPTH / 2;
    localparam int               c_aw         = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_last_phase = CNT_W'(DEPTH - 1);

    if (DEPTH < 4 || (DEPTH % 2) != 0) begin : g_chk_depth
        $error("odd_even_sort: DEPTH must be even and at least 4");
    end
    if (IDX_W < min_idx_w(DEPTH)) begin : g_chk_idx_w
        $error("odd_even_sort: IDX_W too narrow for DEPTH");
    end
    if (CNT_W < min_idx_w(DEPTH + 1)) begin : g_chk_cnt_w
        $error("odd_even_sort: CNT_W too narrow for DEPTH");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  tag;
    } frame_slot_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [IDX_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_phase;
    logic [1:0]        r_clean_run;
    logic              r_descend;
    logic              r_signed;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_sort_done;
    logic [CNT_W-1:0]  r_phases;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [IDX_W-1:0]  r_out_index;
    logic              r_out_last;

    frame_slot_t       w_mem   [DEPTH];
    frame_slot_t       w_even  [DEPTH];
    frame_slot_t       w_odd   [DEPTH];
    frame_slot_t       w_next  [DEPTH];
    logic [c_pairs-1:0] w_even_sw;
    logic [c_pairs-2:0] w_odd_sw;
    logic              w_swapped;
    logic              w_exit;
    logic              w_accept;
    logic [IDX_W-1:0]  w_rd_next;
    frame_slot_t       w_rd_slot;
    frame_slot_t       w_nx_slot;

    assign w_accept  = in_valid && r_in_ready;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign w_rd_slot = w_mem[r_rd_ptr[c_aw-1:0]];
    assign w_nx_slot = w_mem[w_rd_next[c_aw-1:0]];

    // Slot storage carries no reset; its contents are meaningless outside a frame.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        frame_slot_t r_slot;
        always_ff @(posedge clk) begin
            if (r_state == SORT) begin
                r_slot <= w_next[i];
            end else if (w_accept && r_wr_ptr == IDX_W'(i)) begin
                r_slot <= {in_data, r_wr_ptr};
            end
        end
        assign w_mem[i] = r_slot;
    end

    for (genvar k = 0; k < c_pairs; k++) begin : g_even
        cmp_swap_cell #(.SLOT_T(frame_slot_t)) u_cell (
            .i_lo      (w_mem[2*k]),
            .i_hi      (w_mem[2*k+1]),
            .i_descend (r_descend),
            .i_signed  (r_signed),
            .o_lo      (w_even[2*k]),
            .o_hi      (w_even[2*k+1]),
            .o_swapped (w_even_sw[k])
        );
    end

    for (genvar k = 0; k < c_pairs - 1; k++) begin : g_odd
        cmp_swap_cell #(.SLOT_T(frame_slot_t)) u_cell (
            .i_lo      (w_mem[2*k+1]),
            .i_hi      (w_mem[2*k+2]),
            .i_descend (r_descend),
            .i_signed  (r_signed),
            .o_lo      (w_odd[2*k+1]),
            .o_hi      (w_odd[2*k+2]),
            .o_swapped (w_odd_sw[k])
        );
    end

    assign w_odd[0]       = w_mem[0];
    assign w_odd[DEPTH-1] = w_mem[DEPTH-1];

    always_comb begin
        if (r_phase[0]) begin
            w_next    = w_odd;
            w_swapped = |w_odd_sw;
        end else begin
            w_next    = w_even;
            w_swapped = |w_even_sw;
        end
    end

    // A clean phase that follows a clean phase of the other parity proves order.
    assign w_exit = (!w_swapped && r_clean_run == 2'd1) || (r_phase == c_last_phase);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_phase     <= '0;
            r_clean_run <= '0;
            r_descend   <= 1'b0;
            r_signed    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_sort_done <= 1'b0;
            r_phases    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_sort_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        if (r_wr_ptr == '0) begin
                            r_descend <= cfg_descend;
                            r_signed  <= cfg_signed;
                        end
                        if (r_wr_ptr == c_last_idx) begin
                            r_wr_ptr    <= '0;
                            r_phase     <= '0;
                            r_clean_run <= '0;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= SORT;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                SORT: begin
                    r_phase     <= r_phase + 1'b1;
                    r_clean_run <= w_swapped ? 2'd0 : r_clean_run + 1'b1;
                    if (w_exit) begin
                        r_phases    <= r_phase + 1'b1;
                        r_sort_done <= 1'b1;
                        r_rd_ptr    <= '0;
                        r_state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_rd_slot.data;
                        r_out_index <= w_rd_slot.tag;
                        r_out_last  <= (r_rd_ptr == c_last_idx);
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_rd_ptr    <= '0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= LOAD;
                        end else begin
                            r_rd_ptr    <= w_rd_next;
                            r_out_data  <= w_nx_slot.data;
                            r_out_index <= w_nx_slot.tag;
                            r_out_last  <= (w_rd_next == c_last_idx);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign sort_done = r_sort_done;
    assign phases    = r_phases;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_odd_even_sort.sv
`default_nettype none
// ============================================================================
// Module      : tb_odd_even_sort
// Description : Self-checking bench for odd_even_sort against a stable-sort
//               reference model, with backpressure and reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_odd_even_sort;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 8;
    localparam int CNT_W  = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t frame_t [DEPTH];

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_descend;
    logic              cfg_signed;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic              busy;
    logic              sort_done;
    logic [CNT_W-1:0]  phases;

    always #5 clk = ~clk;

    odd_even_sort #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_descend (cfg_descend),
        .cfg_signed  (cfg_signed),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .sort_done   (sort_done),
        .phases      (phases)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    done_cnt = 0;
    word_t exp_d [DEPTH];
    int    exp_i [DEPTH];

    always @(negedge clk) begin
        if (sort_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit key_before(word_t a, word_t b, bit desc, bit sgn);
        longint ka;
        longint kb;
        ka = sgn ? longint'($signed(a)) : longint'(a);
        kb = sgn ? longint'($signed(b)) : longint'(b);
        return desc ? (ka > kb) : (ka < kb);
    endfunction

    // Stable insertion sort over input positions.
    task automatic build_expect(input frame_t v, input bit desc, input bit sgn);
        int tmp;
        for (int i = 0; i < DEPTH; i++) exp_i[i] = i;
        for (int i = 1; i < DEPTH; i++) begin
            for (int j = i; j > 0 && key_before(v[exp_i[j]], v[exp_i[j-1]], desc, sgn); j--) begin
                tmp        = exp_i[j];
                exp_i[j]   = exp_i[j-1];
                exp_i[j-1] = tmp;
            end
        end
        for (int i = 0; i < DEPTH; i++) exp_d[i] = v[exp_i[i]];
    endtask

    // Config is flipped after word 0 so only the first-word sample matters.
    task automatic load_frame(input frame_t v, input bit desc, input bit sgn);
        int w;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid    = 1'b1;
            in_data     = v[i];
            cfg_descend = (i == 0) ? desc : ~desc;
            cfg_signed  = (i == 0) ? sgn : ~sgn;
            w = 0;
            while (!in_ready && w < 200) begin
                tick();
                w++;
            end
            if (w >= 200) begin
                check("load_timeout", w, 0);
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_sort(input string nm, output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) check({nm, "_busy"}, busy, 1);
        end while (!sort_done && n < 4 * DEPTH);
        if (!sort_done) check({nm, "_sort_timeout"}, sort_done, 1);
        check({nm, "_valid_at_done"}, out_valid, 0);
    endtask

    task automatic drain(input string nm, input bit bp, input int n_words);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < n_words && cyc < 400) begin
            tick();
            cyc++;
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (cyc == 1) check({nm, "_first_valid"}, out_valid, 1);
            if (out_valid) begin
                check({nm, "_data"}, out_data, exp_d[k]);
                check({nm, "_index"}, out_index, exp_i[k]);
                check({nm, "_last"}, out_last, (k == DEPTH - 1));
                check({nm, "_no_accept"}, in_ready, 0);
                if (out_ready) k++;
            end
        end
        if (k < n_words) begin
            check({nm, "_drain_timeout"}, k, n_words);
        end else if (n_words == DEPTH) begin
            tick();
            check({nm, "_end_valid"}, out_valid, 0);
            check({nm, "_end_ready"}, in_ready, 1);
            check({nm, "_end_busy"}, busy, 0);
        end
    endtask

    task automatic run_frame(input string nm, input frame_t v, input bit desc, input bit sgn,
                             input bit bp, input int exp_ph);
        int n;
        int d0;
        build_expect(v, desc, sgn);
        d0 = done_cnt;
        load_frame(v, desc, sgn);
        wait_sort(nm, n);
        if (exp_ph != 0) begin
            check({nm, "_phases"}, phases, exp_ph);
            check({nm, "_done_lat"}, n, 2);
        end else begin
            check({nm, "_phases_rng"}, (phases >= 2 && phases <= DEPTH), 1);
            check({nm, "_done_lat_rng"}, (n >= 2 && n <= DEPTH), 1);
        end
        drain(nm, bp, DEPTH);
        check({nm, "_done_once"}, done_cnt - d0, 1);
    endtask

    task automatic pulse_rst(input string nm);
        rst = 1'b1;
        #2;
        check({nm, "_valid"}, out_valid, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_ready"}, in_ready, 1);
        check({nm, "_phases"}, phases, 0);
        #2;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frame_t f;
        frame_t g;
        int     n;

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        cfg_descend = 1'b0; cfg_signed = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_sort_done", sort_done, 0);
        check("rst_phases", phases, 0);
        rst = 1'b0;
        tick();

        f = '{16'd8, 16'd3, 16'd5, 16'd1, 16'd7, 16'd2, 16'd6, 16'd4};
        run_frame("basic", f, 1'b0, 1'b0, 1'b0, 0);

        f = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        run_frame("presorted", f, 1'b0, 1'b0, 1'b0, 2);

        f = '{16'd5, 16'd5, 16'd2, 16'd5, 16'd9, 16'd2, 16'd0, 16'd0};
        run_frame("stable_desc", f, 1'b1, 1'b0, 1'b0, 0);

        f = '{16'hFFFF, 16'h0001, 16'h8000, 16'h0000, 16'h7FFF, 16'h0005, 16'hFFFE, 16'h0003};
        run_frame("signed_asc", f, 1'b0, 1'b1, 1'b0, 0);
        run_frame("unsigned_asc", f, 1'b0, 1'b0, 1'b0, 0);

        // Backpressure with in_valid held high, then an opposite-direction frame.
        f = '{16'd40, 16'd7, 16'd7, 16'd300, 16'd1, 16'd99, 16'd12, 16'd7};
        g = '{16'd3, 16'd14, 16'd15, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
        build_expect(f, 1'b0, 1'b0);
        load_frame(f, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = g[0]; cfg_descend = 1'b1; cfg_signed = 1'b0;
        wait_sort("bp", n);
        drain("bp", 1'b1, DEPTH);
        run_frame("bp_next", g, 1'b1, 1'b0, 1'b1, 0);

        // Reset during SORT.
        f = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        load_frame(f, 1'b0, 1'b0);
        check("pre_rst_sort_busy", busy, 1);
        pulse_rst("rst_sort");
        run_frame("after_rst_sort", f, 1'b0, 1'b0, 1'b0, 0);

        // Reset during DRAIN with the fourth word on the output.
        g = '{16'd11, 16'd4, 16'd29, 16'd4, 16'd0, 16'd17, 16'd8, 16'd2};
        build_expect(g, 1'b1, 1'b0);
        load_frame(g, 1'b1, 1'b0);
        wait_sort("rst_drain", n);
        drain("rst_drain", 1'b0, 3);
        tick();
        out_ready = 1'b0;
        check("rst_drain_idx3", out_index, exp_i[3]);
        pulse_rst("rst_drain");
        run_frame("after_rst_drain", g, 1'b0, 1'b1, 1'b1, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                f[i] = (r < 3) ? DATA_W'($urandom_range(0, 7)) : DATA_W'($urandom);
            end
            run_frame($sformatf("rnd%0d", r), f, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
